// File: rtl/xor_sweep_pkg.sv
// Shared state encoding and widths for the XOR sweep controller.
package xor_sweep_pkg;

    localparam int VEC_W    = 4;
    localparam int ERR_W    = 5;
    localparam int SETTLE_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_e;

endpackage

// File: rtl/xor_sweep_controller_if.sv
// Control and datapath signals between the sweep controller (master) and its environment (slave).
interface xor_sweep_controller_if;
    import xor_sweep_pkg::*;

    logic             start;
    logic             hold;
    logic [VEC_W-1:0] vec_out;
    logic             e_in;
    logic             f_in;
    logic             g_in;
    logic             busy;
    logic             done;
    logic [ERR_W-1:0] err_cnt;
    logic [VEC_W-1:0] first_err_vec;

    modport master (
        input  start, hold, e_in, f_in, g_in,
        output vec_out, busy, done, err_cnt, first_err_vec
    );

    modport slave (
        output start, hold, e_in, f_in, g_in,
        input  vec_out, busy, done, err_cnt, first_err_vec
    );

endinterface

// File: rtl/xor_expected_parity.sv
// Reference XOR outputs for a vector {A,B,C,D}: E=A^B, F=A^B^C, G=A^B^C^D, packed as {E,F,G}.
module xor_expected_parity
    import xor_sweep_pkg::*;
(
    input  logic [VEC_W-1:0] vec,
    output logic [2:0]       efg
);

    logic a, b, c, d;

    assign {a, b, c, d} = vec;
    assign efg = {a ^ b, a ^ b ^ c, a ^ b ^ c ^ d};

endmodule

// File: rtl/xor_sweep_controller.sv
// Sweeps 4-bit vectors through an external XOR datapath and counts mismatching responses.
// Comparison logic is built only when XOR_SWEEP_SELF_CHECK_EN is defined.
module xor_sweep_controller
    import xor_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int LAST_VEC      = 15
)
(
    input logic                    clk,
    input logic                    rst,
    xor_sweep_controller_if.master bus
);

    localparam logic [VEC_W-1:0]    LAST        = VEC_W'(LAST_VEC);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0]    ERR_MAX     = '1;

    state_e              state_q, state_d;
    logic [VEC_W-1:0]    vec_q, vec_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [VEC_W-1:0]    first_q, first_d;
    logic                done_c;
    logic [2:0]          exp_efg;

    xor_expected_parity u_parity (
        .vec (vec_q),
        .efg (exp_efg)
    );

`ifdef XOR_SWEEP_SELF_CHECK_EN
    logic mismatch;
    assign mismatch = ({bus.e_in, bus.f_in, bus.g_in} != exp_efg);
`else
    logic unused_datapath;
    assign unused_datapath = ^{bus.e_in, bus.f_in, bus.g_in, exp_efg};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            vec_q    <= '0;
            settle_q <= '0;
            err_q    <= '0;
            first_q  <= '0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            first_q  <= first_d;
        end
    end

    // hold freezes everything, so all transitions sit under !hold
    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        settle_d = settle_q;
        err_d    = err_q;
        first_d  = first_q;
        done_c   = 1'b0;
        if (!bus.hold) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_d = ST_APPLY;
                        vec_d   = '0;
                        err_d   = '0;
                        first_d = '0;
                    end
                end
                ST_APPLY: begin
                    settle_d = '0;
                    if (SETTLE_CYCLES > 0) state_d = ST_SETTLE;
                    else                   state_d = ST_CHECK;
                end
                ST_SETTLE: begin
                    if (settle_q == SETTLE_LAST) state_d = ST_CHECK;
                    else                         settle_d = settle_q + 1'b1;
                end
                ST_CHECK: begin
`ifdef XOR_SWEEP_SELF_CHECK_EN
                    if (mismatch) begin
                        if (err_q == '0)     first_d = vec_q;
                        if (err_q != ERR_MAX) err_d  = err_q + 1'b1;
                    end
`endif
                    if (vec_q == LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        vec_d   = vec_q + 1'b1;
                        state_d = ST_APPLY;
                    end
                end
                ST_DONE: begin
                    done_c  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign bus.vec_out       = vec_q;
    assign bus.busy          = (state_q != ST_IDLE);
    assign bus.done          = done_c;
    assign bus.err_cnt       = err_q;
    assign bus.first_err_vec = first_q;

endmodule

// File: tb/tb_xor_sweep_controller.sv
// Directed bench for xor_sweep_controller: default instance plus a SETTLE_CYCLES=0, LAST_VEC=3 instance.
// Error-count expectations follow XOR_SWEEP_SELF_CHECK_EN.
module tb_xor_sweep_controller;

`ifdef XOR_SWEEP_SELF_CHECK_EN
    localparam int EXP_ERR_G0   = 8;
    localparam int EXP_FIRST_G0 = 1;
    localparam int EXP_ERR_AT9  = 5;
`else
    localparam int EXP_ERR_G0   = 0;
    localparam int EXP_FIRST_G0 = 0;
    localparam int EXP_ERR_AT9  = 0;
`endif

    logic clk;
    logic rst;
    logic force_g0;
    int   n_cmp;
    int   n_err;

    xor_sweep_controller_if bus ();
    xor_sweep_controller_if bus_s ();

    xor_sweep_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    xor_sweep_controller #(.SETTLE_CYCLES(0), .LAST_VEC(3)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    // golden XOR datapath; G can be stuck at 0 on the default instance
    assign bus.e_in   = bus.vec_out[3] ^ bus.vec_out[2];
    assign bus.f_in   = bus.vec_out[3] ^ bus.vec_out[2] ^ bus.vec_out[1];
    assign bus.g_in   = force_g0 ? 1'b0 : ^bus.vec_out;
    assign bus_s.e_in = bus_s.vec_out[3] ^ bus_s.vec_out[2];
    assign bus_s.f_in = bus_s.vec_out[3] ^ bus_s.vec_out[2] ^ bus_s.vec_out[1];
    assign bus_s.g_in = ^bus_s.vec_out;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic applyStimulusSmall();
        bus_s.start = 1'b1;
        tick();
        bus_s.start = 1'b0;
    endtask

    initial begin
        int n;
        int bad;
        int pulses;
        n_cmp = 0;
        n_err = 0;
        force_g0    = 1'b0;
        bus.start   = 1'b0;
        bus.hold    = 1'b0;
        bus_s.start = 1'b0;
        bus_s.hold  = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("reset_vec",   bus.vec_out, 0);
        checkOutput("reset_busy",  bus.busy, 0);
        checkOutput("reset_done",  bus.done, 0);
        checkOutput("reset_err",   bus.err_cnt, 0);
        checkOutput("reset_first", bus.first_err_vec, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        $display("[TB] golden sweep");
        applyStimulus();
        n = 0; bad = 0;
        while (bus.done !== 1'b1 && n < 200) begin
            if (bus.vec_out !== 4'(n / 4)) bad++;
            if (bus.busy !== 1'b1) bad++;
            tick(); n++;
        end
        checkOutput("golden_latency", n, 64);
        checkOutput("golden_order", bad, 0);
        checkOutput("golden_vec_at_done", bus.vec_out, 15);
        checkOutput("golden_err", bus.err_cnt, 0);
        tick();
        checkOutput("golden_done_pulse", bus.done, 0);
        checkOutput("golden_idle_busy", bus.busy, 0);
        checkOutput("golden_vec_hold", bus.vec_out, 15);

        $display("[TB] G stuck at 0");
        force_g0 = 1'b1;
        applyStimulus();
        n = 0;
        while (bus.done !== 1'b1 && n < 200) begin
            tick(); n++;
        end
        checkOutput("g0_latency", n, 64);
        checkOutput("g0_err", bus.err_cnt, EXP_ERR_G0);
        checkOutput("g0_first", bus.first_err_vec, EXP_FIRST_G0);
        force_g0 = 1'b0;
        tick();
        checkOutput("g0_err_hold", bus.err_cnt, EXP_ERR_G0);
        checkOutput("g0_first_hold", bus.first_err_vec, EXP_FIRST_G0);

        $display("[TB] start re-pulsed mid-sweep and in DONE");
        applyStimulus();
        n = 0;
        while (bus.done !== 1'b1 && n < 200) begin
            bus.start = (n == 20);
            tick(); n++;
        end
        bus.start = 1'b0;
        checkOutput("restart_latency", n, 64);
        checkOutput("restart_err_cleared", bus.err_cnt, 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checkOutput("restart_done_busy", bus.busy, 0);
        pulses = 0; bad = 0;
        repeat (5) begin
            if (bus.done === 1'b1) pulses++;
            if (bus.busy !== 1'b0) bad++;
            tick();
        end
        checkOutput("restart_extra_done", pulses, 0);
        checkOutput("restart_not_queued", bad, 0);

        $display("[TB] hold blocks start in IDLE");
        bus.hold  = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checkOutput("idle_hold_busy", bus.busy, 0);
        bus.hold = 1'b0;
        tick();
        checkOutput("idle_hold_no_queue", bus.busy, 0);

        $display("[TB] hold during SETTLE of vector 5");
        applyStimulus();
        repeat (21) tick();
        n = 21;
        checkOutput("hold_vec_before", bus.vec_out, 5);
        bus.hold = 1'b1;
        bad = 0;
        repeat (10) begin
            tick(); n++;
            if (bus.vec_out !== 4'd5) bad++;
            if (bus.done !== 1'b0) bad++;
        end
        bus.hold = 1'b0;
        checkOutput("hold_frozen", bad, 0);
        while (bus.done !== 1'b1 && n < 300) begin
            tick(); n++;
        end
        checkOutput("hold_latency", n, 74);
        tick();

        $display("[TB] reset during vector 9");
        force_g0 = 1'b1;
        applyStimulus();
        repeat (37) tick();
        checkOutput("rst_mid_vec", bus.vec_out, 9);
        checkOutput("rst_mid_err", bus.err_cnt, EXP_ERR_AT9);
        rst = 1'b1;
        #1;
        checkOutput("rst_async_vec", bus.vec_out, 0);
        checkOutput("rst_async_busy", bus.busy, 0);
        checkOutput("rst_async_done", bus.done, 0);
        checkOutput("rst_async_err", bus.err_cnt, 0);
        checkOutput("rst_async_first", bus.first_err_vec, 0);
        pulses = 0;
        repeat (2) begin
            tick();
            if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
        end
        checkOutput("rst_no_done", pulses, 0);
        rst = 1'b0;
        force_g0 = 1'b0;
        applyStimulus();
        checkOutput("rst_first_edge_start", bus.busy, 1);
        n = 0; bad = 0;
        while (bus.done !== 1'b1 && n < 200) begin
            if (bus.vec_out !== 4'(n / 4)) bad++;
            tick(); n++;
        end
        checkOutput("rst_clean_latency", n, 64);
        checkOutput("rst_clean_order", bad, 0);
        checkOutput("rst_clean_err", bus.err_cnt, 0);
        tick();

        $display("[TB] SETTLE_CYCLES=0 LAST_VEC=3");
        applyStimulusSmall();
        n = 0; bad = 0;
        while (bus_s.done !== 1'b1 && n < 100) begin
            if (bus_s.vec_out !== 4'(n / 2)) bad++;
            tick(); n++;
        end
        checkOutput("small_latency", n, 8);
        checkOutput("small_order", bad, 0);
        checkOutput("small_last_vec", bus_s.vec_out, 3);
        checkOutput("small_err", bus_s.err_cnt, 0);
        tick();
        checkOutput("small_idle", bus_s.busy, 0);

        $display("[TB] DONE waits for hold");
        applyStimulusSmall();
        repeat (8) tick();
        bus_s.hold = 1'b1;
        #1;
        checkOutput("done_hold_done", bus_s.done, 0);
        checkOutput("done_hold_busy", bus_s.busy, 1);
        bad = 0;
        repeat (3) begin
            tick();
            if (bus_s.done !== 1'b0 || bus_s.busy !== 1'b1) bad++;
        end
        checkOutput("done_hold_wait", bad, 0);
        bus_s.hold = 1'b0;
        #1;
        checkOutput("done_hold_release", bus_s.done, 1);
        tick();
        checkOutput("done_hold_idle", bus_s.busy, 0);
        checkOutput("done_hold_pulse_end", bus_s.done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
